// File: rtl/alu_exec_control.sv
// Execute-stage ALU control: funct3/funct7 decode to the 4-bit ALU code, plus
// sequencing of a radix-2 iterative multiply/divide engine for the M extension.
module alu_exec_control #(
   parameter int XLEN  = 32,
   parameter bit M_EXT = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            valid_in,
   input  logic            flush,
   input  logic [31:0]     instruction,
   input  logic [2:0]      alu_op,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   output logic [3:0]      alu_decode,
   output logic            is_muldiv,
   output logic            stall,
   output logic            md_valid,
   output logic [XLEN-1:0] md_result
);

   localparam int CNT_W = $clog2(XLEN) + 1;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_SLL  = 4'b0001;
   localparam logic [3:0] ALU_SRL  = 4'b0010;
   localparam logic [3:0] ALU_SRA  = 4'b1010;
   localparam logic [3:0] ALU_AND  = 4'b0011;
   localparam logic [3:0] ALU_OR   = 4'b0100;
   localparam logic [3:0] ALU_XOR  = 4'b0101;
   localparam logic [3:0] ALU_SLT  = 4'b0110;
   localparam logic [3:0] ALU_SLTU = 4'b0111;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [2:0]        funct3;
   logic [6:0]        funct7;
   logic              unused_instr;

   assign funct3       = instruction[14:12];
   assign funct7       = instruction[31:25];
   assign unused_instr = ^{instruction[24:15], instruction[11:0]};

   function automatic logic [3:0] rtype_code(input logic [2:0] f3);
      case (f3)
         3'b000:  rtype_code = ALU_ADD;
         3'b001:  rtype_code = ALU_SLL;
         3'b010:  rtype_code = ALU_SLT;
         3'b011:  rtype_code = ALU_SLTU;
         3'b100:  rtype_code = ALU_XOR;
         3'b101:  rtype_code = ALU_SRL;
         3'b110:  rtype_code = ALU_OR;
         default: rtype_code = ALU_AND;
      endcase
   endfunction

   function automatic logic [2*XLEN-1:0] cond_neg_w(input logic [2*XLEN-1:0] v, input logic neg);
      cond_neg_w = neg ? -v : v;
   endfunction

   function automatic logic [XLEN-1:0] cond_neg_x(input logic [XLEN-1:0] v, input logic neg);
      cond_neg_x = neg ? -v : v;
   endfunction

   always_comb begin
      alu_decode = ALU_ADD;
      if (reset) begin
         case (alu_op)
            3'b010: begin
               if (funct7 == 7'b0000000) begin
                  alu_decode = rtype_code(funct3);
               end else if (funct7 == 7'b0100000) begin
                  if (funct3 == 3'b000)      alu_decode = ALU_SUB;
                  else if (funct3 == 3'b101) alu_decode = ALU_SRA;
               end
            end
            3'b011: begin
               // I-type: bit 30 is immediate data except for the shift-right form
               if (funct3 == 3'b000)      alu_decode = ALU_ADD;
               else if (funct3 == 3'b101) alu_decode = instruction[30] ? ALU_SRA : ALU_SRL;
               else                       alu_decode = rtype_code(funct3);
            end
            3'b111: begin
               case (funct3)
                  3'b000, 3'b001: alu_decode = ALU_XOR;
                  3'b100, 3'b101: alu_decode = ALU_SLT;
                  3'b110, 3'b111: alu_decode = ALU_SLTU;
                  default:        alu_decode = ALU_ADD;
               endcase
            end
            default: alu_decode = ALU_ADD;
         endcase
      end
   end

   assign is_muldiv = valid_in & (alu_op == 3'b010) & (funct7 == 7'b0000001) & M_EXT;

   logic signed [XLEN-1:0] rs1_s, rs2_s;
   logic                   a_sgn, b_sgn, a_neg, b_neg, res_neg;
   logic [XLEN-1:0]        a_mag, b_mag, special_res;
   logic                   div_zero, div_ovf, special, accept;

   assign rs1_s    = rs1_val;
   assign rs2_s    = rs2_val;
   assign a_sgn    = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
   assign b_sgn    = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
   assign a_neg    = a_sgn & (rs1_s < 0);
   assign b_neg    = b_sgn & (rs2_s < 0);
   assign a_mag    = a_neg ? -rs1_val : rs1_val;
   assign b_mag    = b_neg ? -rs2_val : rs2_val;
   // Remainder follows the dividend; quotient and product follow the sign product.
   assign res_neg  = (funct3[2] & funct3[1]) ? a_neg : (a_neg ^ b_neg);
   assign div_zero = funct3[2] & (rs2_val == '0);
   assign div_ovf  = funct3[2] & ~funct3[0] & (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) & (rs2_val == '1);
   assign special  = div_zero | div_ovf;
   assign accept   = is_muldiv & ~flush & (state == IDLE);

   always_comb begin
      if (div_zero) special_res = funct3[1] ? rs1_val : '1;
      else          special_res = funct3[1] ? '0 : rs1_val;
   end

   // Engine registers: loaded at acceptance, iterated in BUSY
   logic [2*XLEN-1:0] acc_p0;
   logic [XLEN-1:0]   bmag_p0, spec_res_p0;
   logic [2:0]        f3_p0;
   logic              neg_p0, spec_p0;

   logic [XLEN:0]     mul_sum, div_trial;
   logic              div_fit;
   logic [2*XLEN-1:0] mul_next, div_next;

   assign mul_sum   = {1'b0, acc_p0[2*XLEN-1:XLEN]} + (acc_p0[0] ? {1'b0, bmag_p0} : '0);
   assign mul_next  = {mul_sum, acc_p0[XLEN-1:1]};
   assign div_trial = acc_p0[2*XLEN-1:XLEN-1] - {1'b0, bmag_p0};
   assign div_fit   = ~div_trial[XLEN];
   assign div_next  = {(div_fit ? div_trial[XLEN-1:0] : acc_p0[2*XLEN-2:XLEN-1]),
                       acc_p0[XLEN-2:0], div_fit};

   always_ff @(posedge clk) begin
      if (accept) begin
         acc_p0      <= {{XLEN{1'b0}}, a_mag};
         bmag_p0     <= b_mag;
         f3_p0       <= funct3;
         neg_p0      <= res_neg;
         spec_p0     <= special;
         spec_res_p0 <= special_res;
      end else if (state == BUSY) begin
         acc_p0 <= f3_p0[2] ? div_next : mul_next;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = special ? DONE : BUSY;
         BUSY: begin
            if (flush)                  state_nxt = IDLE;
            else if (cnt == LAST_ITER)  state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Result stage: sign correction and half select while in DONE
   logic [2*XLEN-1:0] prod_fix_p1;
   logic [XLEN-1:0]   div_fix_p1, md_final_p1, res_hold_p1;

   assign prod_fix_p1 = cond_neg_w(acc_p0, neg_p0);
   assign div_fix_p1  = cond_neg_x(f3_p0[1] ? acc_p0[2*XLEN-1:XLEN] : acc_p0[XLEN-1:0], neg_p0);

   always_comb begin
      if (spec_p0)               md_final_p1 = spec_res_p0;
      else if (f3_p0[2])         md_final_p1 = div_fix_p1;
      else if (f3_p0 == 3'b000)  md_final_p1 = prod_fix_p1[XLEN-1:0];
      else                       md_final_p1 = prod_fix_p1[2*XLEN-1:XLEN];
   end

   assign md_valid  = reset & (state == DONE) & ~flush;
   assign md_result = md_valid ? md_final_p1 : res_hold_p1;
   assign stall     = reset & is_muldiv & ~flush & ((state == IDLE) | (state == BUSY));

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         cnt         <= '0;
         res_hold_p1 <= '0;
      end else begin
         state <= state_nxt;
         if (accept)               cnt <= '0;
         else if (state == BUSY)   cnt <= cnt + CNT_W'(1);
         if (md_valid)             res_hold_p1 <= md_final_p1;
      end
   end

endmodule

// File: tb/tb_alu_exec_control.sv
// Directed bench for alu_exec_control: decode vector table plus hand-written
// multiply/divide, flush and reset sequences with hand-computed results.
module tb_alu_exec_control;

   logic        clk, reset, valid_in, flush;
   logic [31:0] instruction, rs1_val, rs2_val;
   logic [2:0]  alu_op;
   logic [3:0]  alu_decode;
   logic        is_muldiv, stall, md_valid;
   logic [31:0] md_result;

   int total = 0;
   int bad   = 0;

   alu_exec_control #(.XLEN(32), .M_EXT(1'b1)) dut (
      .clk(clk), .reset(reset), .valid_in(valid_in), .flush(flush),
      .instruction(instruction), .alu_op(alu_op), .rs1_val(rs1_val), .rs2_val(rs2_val),
      .alu_decode(alu_decode), .is_muldiv(is_muldiv), .stall(stall),
      .md_valid(md_valid), .md_result(md_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic       v;
      logic       fl;
      logic [2:0] op;
      logic [6:0] f7;
      logic [2:0] f3;
      logic [3:0] dec;
      logic       md;
   } dvec_t;

   dvec_t dv[$];

   function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3);
      return {f7, 10'h000, f3, 5'h00, 7'h33};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic run_md(input string nm, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
      int stalls;
      int vcyc;
      @(posedge clk); #1;
      valid_in = 1'b1; flush = 1'b0; alu_op = 3'b010;
      instruction = mk(7'b0000001, f3); rs1_val = a; rs2_val = b;
      stalls = 0; vcyc = -1;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (stall) stalls++;
         if (md_valid) begin
            vcyc = c;
            chk({nm, " result"}, md_result, exp);
            chk({nm, " stall at valid"}, {31'b0, stall}, 32'd0);
            break;
         end
         @(posedge clk); #1;
      end
      chk({nm, " valid cycle"}, vcyc, lat);
      chk({nm, " stall cycles"}, stalls, lat);
   endtask

   task automatic go_idle(input string nm, input logic [31:0] hold);
      @(posedge clk); #1;
      valid_in = 1'b0;
      @(negedge clk);
      chk({nm, " idle stall"}, {31'b0, stall}, 32'd0);
      chk({nm, " idle md_valid"}, {31'b0, md_valid}, 32'd0);
      chk({nm, " held result"}, md_result, hold);
   endtask

   initial begin
      int seen;
      int stalls;

      dv.push_back('{1'b1, 1'b0, 3'b000, 7'b0000000, 3'b111, 4'b0000, 1'b0});
      dv.push_back('{1'b1, 1'b0, 3'b010, 7'b0000000, 3'b000, 4'b0000, 1'b0});
      dv.push_back('{1'b1, 1'b0, 3'b010, 7'b0100000, 3'b000, 4'b1000, 1'b0});
      dv.push_back('{1'b1, 1'b0, 3'b010, 7'b0100000, 3'b101, 4'b1010, 1'b0});
      dv.push_back('{1'b1, 1'b0, 3'b010, 7'b0000000, 3'b001, 4'b0001, 1'b0});
      dv.push_back('{1'b1, 1'b0, 3'b010, 7'b0000000, 3'b011, 4'b0111, 1'b0});
      dv.push_back('{1'b1, 1'b0, 3'b010, 7'b0000000, 3'b101, 4'b0010, 1'b0});
      dv.push_back('{1'b1, 1'b0, 3'b010, 7'b0000000, 3'b110, 4'b0100, 1'b0});
      dv.push_back('{1'b1, 1'b0, 3'b010, 7'b0000000, 3'b111, 4'b0011, 1'b0});
      dv.push_back('{1'b1, 1'b0, 3'b010, 7'b0100000, 3'b001, 4'b0000, 1'b0});
      dv.push_back('{1'b1, 1'b0, 3'b011, 7'b0100000, 3'b101, 4'b1010, 1'b0});
      dv.push_back('{1'b1, 1'b0, 3'b011, 7'b0000000, 3'b101, 4'b0010, 1'b0});
      dv.push_back('{1'b1, 1'b0, 3'b011, 7'b0100000, 3'b000, 4'b0000, 1'b0});
      dv.push_back('{1'b1, 1'b0, 3'b011, 7'b0000000, 3'b100, 4'b0101, 1'b0});
      dv.push_back('{1'b1, 1'b0, 3'b011, 7'b0000000, 3'b010, 4'b0110, 1'b0});
      dv.push_back('{1'b1, 1'b0, 3'b111, 7'b0000000, 3'b000, 4'b0101, 1'b0});
      dv.push_back('{1'b1, 1'b0, 3'b111, 7'b0000000, 3'b101, 4'b0110, 1'b0});
      dv.push_back('{1'b1, 1'b0, 3'b111, 7'b0000000, 3'b110, 4'b0111, 1'b0});
      dv.push_back('{1'b1, 1'b0, 3'b111, 7'b0000000, 3'b011, 4'b0000, 1'b0});
      dv.push_back('{1'b1, 1'b0, 3'b101, 7'b0000000, 3'b001, 4'b0000, 1'b0});
      dv.push_back('{1'b0, 1'b0, 3'b010, 7'b0000001, 3'b000, 4'b0000, 1'b0});
      dv.push_back('{1'b1, 1'b1, 3'b010, 7'b0000001, 3'b100, 4'b0000, 1'b1});

      // reset: decode forced to 0, control outputs idle
      reset = 1'b0; valid_in = 1'b1; flush = 1'b0; alu_op = 3'b010;
      instruction = mk(7'b0100000, 3'b000); rs1_val = 32'd0; rs2_val = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset alu_decode", {28'b0, alu_decode}, 32'd0);
      chk("reset stall", {31'b0, stall}, 32'd0);
      chk("reset md_valid", {31'b0, md_valid}, 32'd0);
      chk("reset md_result", md_result, 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;

      for (int i = 0; i < dv.size(); i++) begin
         @(posedge clk); #1;
         valid_in = dv[i].v; flush = dv[i].fl; alu_op = dv[i].op;
         instruction = mk(dv[i].f7, dv[i].f3);
         @(negedge clk);
         chk($sformatf("decode[%0d] alu_decode", i), {28'b0, alu_decode}, {28'b0, dv[i].dec});
         chk($sformatf("decode[%0d] is_muldiv", i), {31'b0, is_muldiv}, {31'b0, dv[i].md});
         chk($sformatf("decode[%0d] stall", i), {31'b0, stall}, 32'd0);
      end
      @(posedge clk); #1;
      flush = 1'b0; valid_in = 1'b0;

      // back-to-back M ops, each accepted the cycle after the previous DONE
      run_md("MUL 7*-3",         3'b000, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 33);
      run_md("MULHU ff*ff",      3'b011, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 33);
      run_md("MULH ff*ff",       3'b001, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000, 33);
      run_md("MULHSU ff*ff",     3'b010, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 33);
      run_md("DIV overflow",     3'b100, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1);
      run_md("DIVU by zero",     3'b101, 32'h00001234,   32'd0,        32'hFFFFFFFF, 1);
      run_md("REM 7/0",          3'b110, 32'd7,          32'd0,        32'd7,        1);
      run_md("REM -7/2",         3'b110, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 33);
      run_md("DIV -100/7",       3'b100, 32'hFFFFFF9C,   32'd7,        32'hFFFFFFF2, 33);
      run_md("REMU 100/7",       3'b111, 32'd100,        32'd7,        32'd2,        33);
      go_idle("after REMU", 32'd2);

      // flush a DIV in its 11th cycle, then a MUL must run with full latency
      @(posedge clk); #1;
      valid_in = 1'b1; alu_op = 3'b010; instruction = mk(7'b0000001, 3'b100);
      rs1_val = 32'd1000; rs2_val = 32'd3;
      seen = 0; stalls = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (md_valid) seen++;
         if (stall) stalls++;
         @(posedge clk); #1;
      end
      flush = 1'b1;
      @(negedge clk);
      if (md_valid) seen++;
      chk("flush pre-stall cycles", stalls, 10);
      chk("flush stall dropped", {31'b0, stall}, 32'd0);
      chk("flush no md_valid", seen, 0);
      chk("flush result unchanged", md_result, 32'd2);
      run_md("MUL after flush", 3'b000, 32'd123, 32'd456, 32'h0000DB18, 33);

      // reset pulled in the 6th cycle of a MUL aborts it
      @(posedge clk); #1;
      alu_op = 3'b010; instruction = mk(7'b0000001, 3'b000);
      rs1_val = 32'd6; rs2_val = 32'd7; valid_in = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
      end
      reset = 1'b0;
      @(negedge clk);
      chk("reset mid-busy md_valid", {31'b0, md_valid}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b1; valid_in = 1'b0;
      @(negedge clk);
      chk("after reset stall", {31'b0, stall}, 32'd0);
      chk("after reset md_valid", {31'b0, md_valid}, 32'd0);
      chk("after reset md_result", md_result, 32'd0);
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (md_valid) seen++;
      end
      chk("aborted op no md_valid", seen, 0);
      run_md("MULHU after reset", 3'b011, 32'h80000000, 32'd4, 32'd2, 33);
      go_idle("after MULHU", 32'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
